vote: RTL and testbench

//  Electronic voting-machine core. A poll worker arms one ballot; the voter

---
 rtl/vote_if.sv | 13 +
 rtl/vote.sv | 125 ++++++++++++
 tb/tb_vote.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vote_if.sv
// Front-panel button / display bundle for the voting-machine core.
interface vote_if;
   logic        Close;
   logic        Clear;
   logic        Ballot;
   logic        Total;
   logic        Result;
   logic [3:0]  IN;
   logic [11:0] out;

   modport master (output Close, Clear, Ballot, Total, Result, IN, input out);
   modport slave  (input Close, Clear, Ballot, Total, Result, IN, output out);
endinterface

// File: rtl/vote.sv
// Voting-machine core: ballot arming, per-candidate and total tallies,
// and a stepped result display after the poll closes.
//
// state    | meaning
// S_OPEN   | poll open, no ballot armed
// S_ARMED  | one vote may be cast
// S_CLOSED | poll ended, tallies frozen, Result steps the display
module vote #(
   parameter int NUM_CAND = 9,
   parameter int CNT_W    = 8
) (
   input  logic   clk,
   input  logic   Power,
   vote_if.slave  bus
);
   typedef enum logic [1:0] {S_OPEN, S_ARMED, S_CLOSED} state_t;

   state_t            state_q, state_d;
   logic              prev_close, prev_clear, prev_ballot, prev_total, prev_result;
   logic              close_e, clear_e, ballot_e, total_e, result_e;
   logic [CNT_W-1:0]  cnt [NUM_CAND];
   logic [11:0]       total_q;
   logic [11:0]       out_q;
   logic [3:0]        idx_q;
   logic              in_valid;
   logic              do_clear, do_close, do_total, do_vote, do_result;
   logic [3:0]        win_id;
   logic [CNT_W-1:0]  win_cnt;
   logic [11:0]       res_word;

   assign close_e  = bus.Close  & ~prev_close;
   assign clear_e  = bus.Clear  & ~prev_clear;
   assign ballot_e = bus.Ballot & ~prev_ballot;
   assign total_e  = bus.Total  & ~prev_total;
   assign result_e = bus.Result & ~prev_result;
   assign in_valid = (bus.IN != 4'd0) && (bus.IN <= 4'(NUM_CAND));
   assign bus.out  = out_q;

   always_ff @(posedge clk) begin
      if (!Power) state_q <= S_OPEN;
      else        state_q <= state_d;
   end

   // Only the highest-priority pending action is taken on a given edge.
   always_comb begin
      state_d   = state_q;
      do_clear  = 1'b0;
      do_close  = 1'b0;
      do_total  = 1'b0;
      do_vote   = 1'b0;
      do_result = 1'b0;
      if (clear_e) begin
         do_clear = 1'b1;
         state_d  = S_OPEN;
      end else if (close_e && state_q != S_CLOSED) begin
         do_close = 1'b1;
         state_d  = S_CLOSED;
      end else if (total_e) begin
         do_total = 1'b1;
      end else if (state_q == S_ARMED && in_valid) begin
         do_vote = 1'b1;
         state_d = S_OPEN;
      end else if (ballot_e && state_q == S_OPEN) begin
         state_d = S_ARMED;
      end else if (result_e && state_q == S_CLOSED) begin
         do_result = 1'b1;
      end
   end

   // Strict compare keeps the lowest id on ties; all-zero tallies give id 0.
   always_comb begin
      win_id  = 4'd0;
      win_cnt = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         if (cnt[i] > win_cnt) begin
            win_id  = 4'(i + 1);
            win_cnt = cnt[i];
         end
      end
   end

   always_comb begin
      if (idx_q == 4'd0) res_word = 12'({win_id, win_cnt});
      else               res_word = 12'({idx_q, cnt[idx_q - 4'd1]});
   end

   always_ff @(posedge clk) begin
      if (!Power) begin
         prev_close  <= 1'b0;
         prev_clear  <= 1'b0;
         prev_ballot <= 1'b0;
         prev_total  <= 1'b0;
         prev_result <= 1'b0;
         for (int i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
         total_q <= '0;
         idx_q   <= '0;
         out_q   <= '0;
      end else begin
         prev_close  <= bus.Close;
         prev_clear  <= bus.Clear;
         prev_ballot <= bus.Ballot;
         prev_total  <= bus.Total;
         prev_result <= bus.Result;
         if (do_clear) begin
            for (int i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
            total_q <= '0;
            idx_q   <= '0;
            out_q   <= '0;
         end
         if (do_close) idx_q <= '0;
         if (do_total) out_q <= total_q;
         if (do_vote) begin
            for (int i = 0; i < NUM_CAND; i++) begin
               if (4'(i + 1) == bus.IN && cnt[i] != {CNT_W{1'b1}})
                  cnt[i] <= cnt[i] + CNT_W'(1);
            end
            if (total_q != 12'hFFF) total_q <= total_q + 12'd1;
         end
         if (do_result) begin
            out_q <= res_word;
            idx_q <= (idx_q == 4'(NUM_CAND)) ? 4'd0 : idx_q + 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_vote.sv
// Bench for the voting-machine core: fixed vector table, hand-written corner
// sequences, then randomized button traffic against a tally model.
module tb_vote;
   localparam int NC = 9;

   logic clk = 1'b0;
   logic Power = 1'b0;
   always #5 clk = ~clk;

   vote_if vif();
   vote #(.NUM_CAND(NC), .CNT_W(8)) dut (.clk(clk), .Power(Power), .bus(vif));

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_cnt [1:NC];
   int m_total, m_idx, m_out;
   bit m_closed, m_armed;
   bit p_close, p_clear, p_ballot, p_total, p_result;

   function automatic void m_zero();
      for (int k = 1; k <= NC; k++) m_cnt[k] = 0;
      m_total = 0; m_idx = 0; m_out = 0; m_closed = 0; m_armed = 0;
   endfunction

   function automatic int m_display(int idx);
      int best, bid;
      if (idx != 0) return idx * 256 + m_cnt[idx];
      best = 0;
      for (int k = 1; k <= NC; k++) if (m_cnt[k] > best) best = m_cnt[k];
      bid = 0;
      if (best > 0)
         for (int k = NC; k >= 1; k--) if (m_cnt[k] == best) bid = k;
      return bid * 256 + best;
   endfunction

   function automatic void m_step();
      bit ce, cle, be, te, re;
      int in_v;
      if (!Power) begin
         m_zero();
         p_close = 0; p_clear = 0; p_ballot = 0; p_total = 0; p_result = 0;
         return;
      end
      ce  = vif.Close  && !p_close;
      cle = vif.Clear  && !p_clear;
      be  = vif.Ballot && !p_ballot;
      te  = vif.Total  && !p_total;
      re  = vif.Result && !p_result;
      p_close = vif.Close; p_clear = vif.Clear; p_ballot = vif.Ballot;
      p_total = vif.Total; p_result = vif.Result;
      in_v = int'(vif.IN);
      if (cle) m_zero();
      else if (ce && !m_closed) begin
         m_closed = 1; m_armed = 0; m_idx = 0;
      end else if (te) m_out = m_total;
      else if (m_armed && in_v >= 1 && in_v <= NC) begin
         if (m_cnt[in_v] < 255) m_cnt[in_v]++;
         if (m_total < 4095) m_total++;
         m_armed = 0;
      end else if (be && !m_closed && !m_armed) m_armed = 1;
      else if (re && m_closed) begin
         m_out = m_display(m_idx);
         m_idx = (m_idx + 1) % (NC + 1);
      end
   endfunction

   task automatic tick();
      m_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string nm, int exp);
      checks++;
      if (vif.out !== 12'(exp)) begin
         errors++;
         $display("FAIL %s: out=%03h expected %03h", nm, vif.out, 12'(exp));
      end
   endtask

   task automatic set_in(bit cl, bit clr, bit b, bit t, bit r, logic [3:0] in);
      vif.Close = cl; vif.Clear = clr; vif.Ballot = b;
      vif.Total = t; vif.Result = r; vif.IN = in;
   endtask

   task automatic press_clear();
      vif.Clear = 1; tick(); vif.Clear = 0; tick();
   endtask
   task automatic press_close();
      vif.Close = 1; tick(); vif.Close = 0; tick();
   endtask
   task automatic press_total();
      vif.Total = 1; tick(); vif.Total = 0; tick();
   endtask
   task automatic press_result();
      vif.Result = 1; tick(); vif.Result = 0; tick();
   endtask
   task automatic vote_for(logic [3:0] k);
      vif.Ballot = 1; tick();
      vif.Ballot = 0; vif.IN = k; tick();
      vif.IN = 0;
   endtask

   typedef struct {
      bit close, clear, ballot, total, result;
      logic [3:0] in;
      logic [11:0] exp;
   } vec_t;
   vec_t tbl [19];

   initial begin
      tbl[0]  = '{0,1,0,0,0, 4'd0,  12'h000};
      tbl[1]  = '{0,0,1,0,0, 4'd0,  12'h000};
      tbl[2]  = '{0,0,0,0,0, 4'd1,  12'h000};
      tbl[3]  = '{0,0,0,0,0, 4'd2,  12'h000};
      tbl[4]  = '{0,0,0,1,0, 4'd0,  12'h001};
      tbl[5]  = '{0,0,1,0,0, 4'd15, 12'h001};
      tbl[6]  = '{0,0,0,0,0, 4'd15, 12'h001};
      tbl[7]  = '{0,0,0,0,0, 4'd5,  12'h001};
      tbl[8]  = '{0,0,0,1,0, 4'd0,  12'h002};
      tbl[9]  = '{0,0,0,0,1, 4'd0,  12'h002};
      tbl[10] = '{1,0,0,0,0, 4'd0,  12'h002};
      tbl[11] = '{0,0,0,0,1, 4'd0,  12'h101};
      tbl[12] = '{0,0,0,0,0, 4'd0,  12'h101};
      tbl[13] = '{0,0,0,0,1, 4'd0,  12'h101};
      tbl[14] = '{0,0,0,0,0, 4'd0,  12'h101};
      tbl[15] = '{0,0,0,0,1, 4'd0,  12'h200};
      tbl[16] = '{0,0,1,0,0, 4'd2,  12'h200};
      tbl[17] = '{0,0,0,1,0, 4'd2,  12'h002};
      tbl[18] = '{0,0,0,0,0, 4'd0,  12'h002};

      set_in(0, 0, 0, 0, 0, 4'd0);
      Power = 0;
      tick();
      check("reset", 0);
      Power = 1;

      for (int i = 0; i < 19; i++) begin
         set_in(tbl[i].close, tbl[i].clear, tbl[i].ballot, tbl[i].total,
                tbl[i].result, tbl[i].in);
         tick();
         check($sformatf("vec%0d", i), int'(tbl[i].exp));
      end
      set_in(0, 0, 0, 0, 0, 4'd0);

      // one Ballot, IN held for 20 cycles counts once
      press_clear();
      check("clear", 0);
      vif.Ballot = 1; tick();
      vif.Ballot = 0; vif.IN = 1;
      repeat (20) tick();
      vif.IN = 0;
      press_total();
      check("held_in_total", 1);

      // 5/5 tie between cand1 and cand3, full result walk and wrap
      press_clear();
      for (int i = 0; i < 5; i++) vote_for(4'd1);
      for (int i = 0; i < 5; i++) vote_for(4'd3);
      press_close();
      for (int k = 0; k <= NC + 1; k++) begin
         int e;
         press_result();
         if (k == 0 || k == NC + 1) e = 12'h105;
         else if (k == 1 || k == 3) e = k * 256 + 5;
         else e = k * 256;
         check($sformatf("result%0d", k), e);
      end

      // closed poll ignores ballots and votes
      vote_for(4'd2);
      check("closed_ballot_out", 12'h105);
      press_total();
      check("closed_total", 10);
      press_result();
      check("closed_frozen", 12'h105);

      // Result before Close, then saturation at 255
      press_clear();
      vote_for(4'd1);
      press_total();
      check("total_one", 1);
      press_result();
      check("result_open_ignored", 1);
      for (int i = 0; i < 256; i++) vote_for(4'd1);
      press_total();
      check("total_257", 257);
      press_close();
      press_result();
      check("saturated_winner", 12'h1FF);
      press_clear();
      check("clear_after_sat", 0);
      vote_for(4'd2);
      press_total();
      check("vote_after_clear", 1);

      // Close discards an armed ballot
      press_clear();
      vote_for(4'd4);
      vif.Ballot = 1; tick(); vif.Ballot = 0;
      press_close();
      vif.IN = 4; tick(); vif.IN = 0;
      press_result();
      check("armed_discarded", 12'h401);
      press_total();
      check("armed_discard_total", 1);

      // Power drop while ARMED
      press_clear();
      vote_for(4'd6);
      press_total();
      check("pre_power_total", 1);
      vif.Ballot = 1; tick();
      Power = 0; tick();
      check("power_off", 0);
      Power = 1; vif.Ballot = 0; vif.IN = 3; tick();
      vif.IN = 0;
      press_total();
      check("no_vote_after_power", 0);

      // randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         Power      = ($urandom_range(0, 499) != 0);
         vif.Close  = ($urandom_range(0, 99) < 3);
         vif.Clear  = ($urandom_range(0, 199) < 1);
         vif.Ballot = ($urandom_range(0, 99) < 35);
         vif.Total  = ($urandom_range(0, 99) < 15);
         vif.Result = ($urandom_range(0, 99) < 40);
         vif.IN     = 4'($urandom_range(0, 15));
         tick();
         checks++;
         if (vif.out !== 12'(m_out)) begin
            errors++;
            $display("FAIL rand%0d: out=%03h expected %03h", c, vif.out, 12'(m_out));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
